// File: rtl/instr_split_queue_if.sv
// Fetch/decode bundle for instr_split_queue: fetch handshake, decode handshake,
// pre-split head fields, occupancy and the branch-redirect flush.
interface instr_split_queue_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PC_W  = 32
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [5:0]      op;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic [4:0]      shamt;
   logic [5:0]      func;
   logic [15:0]     imm16;
   logic [25:0]     imm26;
   logic [CW-1:0]   count;

   // Queue side
   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, op, rs, rt, rd, shamt, func,
             imm16, imm26, count
   );

   // Fetch/decode side
   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, op, rs, rt, rd, shamt, func,
             imm16, imm26, count
   );
endinterface

// File: rtl/instr_split_queue.sv
// instr_split_queue: circular fetch-to-decode instruction buffer that presents
// its head entry pre-split into MIPS fields. Synchronous flush for redirect.
// Optional macro INSTR_Q_BYPASS_EN: when the queue is empty, the incoming
// instruction is forwarded combinationally (0-cycle latency).
module instr_split_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PC_W  = 32
) (
   input logic                clk,
   input logic                rst_n,
   instr_split_queue_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;

   logic   full_c;
   logic   empty_c;
   logic   bypass_c;
   logic   in_ready_c;
   logic   out_valid_c;
   logic   wr_en_c;
   logic   rd_en_c;
   entry_t in_entry_c;
   entry_t head_c;
   entry_t shown_c;

   // Occupancy status, handshakes and head selection
   always_comb begin
      full_c     = (count_q == CW'(DEPTH));
      empty_c    = (count_q == '0);
      in_entry_c = '{pc: bus.in_pc, instr: bus.in_instr};
`ifdef INSTR_Q_BYPASS_EN
      bypass_c   = empty_c & ~bus.flush;
`else
      bypass_c   = 1'b0;
`endif
      in_ready_c  = ~full_c & ~bus.flush;
      out_valid_c = ~bus.flush & (~empty_c | (bypass_c & bus.in_valid));
      head_c      = bypass_c ? in_entry_c : mem_q[rd_ptr_q];
      // A bypassed word consumed in the same cycle is never stored
      wr_en_c     = bus.in_valid & in_ready_c & ~(bypass_c & bus.out_ready);
      rd_en_c     = out_valid_c & bus.out_ready & ~bypass_c;
      shown_c     = out_valid_c ? head_c : '0;
   end

   // Next-state for pointers and count; flush overrides everything
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en_c) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(wr_en_c) - CW'(rd_en_c);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[wr_ptr_q] <= in_entry_c;
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.count     = count_q;
   assign bus.out_pc    = shown_c.pc;
   assign bus.op        = shown_c.instr[31:26];
   assign bus.rs        = shown_c.instr[25:21];
   assign bus.rt        = shown_c.instr[20:16];
   assign bus.rd        = shown_c.instr[15:11];
   assign bus.shamt     = shown_c.instr[10:6];
   assign bus.func      = shown_c.instr[5:0];
   assign bus.imm16     = shown_c.instr[15:0];
   assign bus.imm26     = shown_c.instr[25:0];
endmodule

// File: tb/tb_instr_split_queue.sv
// Directed table-driven bench for instr_split_queue (DEPTH=4, PC_W=32).
module tb_instr_split_queue;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   instr_split_queue_if #(.DEPTH(4), .PC_W(32)) bus ();

   instr_split_queue #(.DEPTH(4), .PC_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        ordy;
      logic        e_irdy;
      logic        e_ov;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      int          e_cnt;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic fl, input logic iv, input logic [31:0] instr,
                      input logic [31:0] pc, input logic ordy, input logic e_irdy,
                      input logic e_ov, input logic [31:0] e_instr,
                      input logic [31:0] e_pc, input int e_cnt);
      vec_t v;
      v.fl = fl; v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy;
      v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_instr = e_instr; v.e_pc = e_pc;
      v.e_cnt = e_cnt;
      vt.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Head presentation: fields come from the expected word, or all zero when invalid
   task automatic check_out(input string tag, input logic ev, input logic [31:0] ei,
                            input logic [31:0] ep);
      logic [31:0] w;
      logic [31:0] p;
      w = ev ? ei : 32'h0;
      p = ev ? ep : 32'h0;
      check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
      check({tag, ".out_pc"},    64'(bus.out_pc),    64'(p));
      check({tag, ".op"},        64'(bus.op),        64'(w[31:26]));
      check({tag, ".rs"},        64'(bus.rs),        64'(w[25:21]));
      check({tag, ".rt"},        64'(bus.rt),        64'(w[20:16]));
      check({tag, ".rd"},        64'(bus.rd),        64'(w[15:11]));
      check({tag, ".shamt"},     64'(bus.shamt),     64'(w[10:6]));
      check({tag, ".func"},      64'(bus.func),      64'(w[5:0]));
      check({tag, ".imm16"},     64'(bus.imm16),     64'(w[15:0]));
      check({tag, ".imm26"},     64'(bus.imm26),     64'(w[25:0]));
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [31:0] instr,
                        input logic [31:0] pc, input logic ordy);
      bus.flush = fl; bus.in_valid = iv; bus.in_instr = instr;
      bus.in_pc = pc; bus.out_ready = ordy;
   endtask

   function automatic logic [31:0] cw(input int k);
      return 32'h2108_0000 + 32'(k);
   endfunction
   function automatic logic [31:0] dw(input int k);
      return 32'hAC00_0000 + 32'(k);
   endfunction

   localparam logic [31:0] A = 32'h012A_4020;
   localparam logic [31:0] B = 32'h8D09_0004;
   localparam logic [31:0] E = 32'h3C01_1234;
   localparam logic [31:0] X = 32'hDEAD_BEEF;

   initial begin
      string tag;
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // basic enqueue/dequeue
      add(0,1,A,32'h3000,0, 1,0,0,0,0);
      add(0,1,B,32'h3004,0, 1,1,A,32'h3000,1);
      add(0,0,0,0,1,        1,1,A,32'h3000,2);
      add(0,0,0,0,1,        1,1,B,32'h3004,1);
      add(0,0,0,0,0,        1,0,0,0,0);
      // fill to full, fifth word held, pops cross pointer wrap
      add(0,1,cw(0),32'h100,0, 1,0,0,0,0);
      add(0,1,cw(1),32'h104,0, 1,1,cw(0),32'h100,1);
      add(0,1,cw(2),32'h108,0, 1,1,cw(0),32'h100,2);
      add(0,1,cw(3),32'h10C,0, 1,1,cw(0),32'h100,3);
      add(0,1,cw(4),32'h110,0, 0,1,cw(0),32'h100,4);
      add(0,1,cw(4),32'h110,0, 0,1,cw(0),32'h100,4);
      add(0,1,cw(4),32'h110,1, 0,1,cw(0),32'h100,4);
      add(0,1,cw(4),32'h110,0, 1,1,cw(1),32'h104,3);
      add(0,0,0,0,1,           0,1,cw(1),32'h104,4);
      add(0,0,0,0,1,           1,1,cw(2),32'h108,3);
      add(0,0,0,0,1,           1,1,cw(3),32'h10C,2);
      add(0,0,0,0,1,           1,1,cw(4),32'h110,1);
      add(0,0,0,0,0,           1,0,0,0,0);
      // steady state at count=2 with simultaneous push/pop
      add(0,1,dw(0),32'h200,0, 1,0,0,0,0);
      add(0,1,dw(1),32'h204,0, 1,1,dw(0),32'h200,1);
      for (int k = 0; k < 10; k++)
         add(0,1,dw(k+2),32'h200+32'(4*(k+2)),1, 1,1,dw(k),32'h200+32'(4*k),2);
      // flush at count=3 with an incoming word that must be dropped
      add(0,1,dw(12),32'h230,0, 1,1,dw(10),32'h228,2);
      add(1,1,X,32'h999,1,      0,0,0,0,3);
      add(0,0,0,0,0,            1,0,0,0,0);
      add(0,1,E,32'h400,0,      1,0,0,0,0);
      add(0,0,0,0,1,            1,1,E,32'h400,1);
      add(0,0,0,0,0,            1,0,0,0,0);

      repeat (2) @(posedge clk);
      #1;
      check("reset.in_ready", 64'(bus.in_ready), 64'd1);
      check("reset.count",    64'(bus.count),    64'd0);
      check_out("reset", 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifndef INSTR_Q_BYPASS_EN
      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].fl, vt[i].iv, vt[i].instr, vt[i].pc, vt[i].ordy);
         @(negedge clk);
         tag = $sformatf("v%0d", i);
         check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(vt[i].e_irdy));
         check({tag, ".count"},    64'(bus.count),    64'(vt[i].e_cnt));
         check_out(tag, vt[i].e_ov, vt[i].e_instr, vt[i].e_pc);
         if (i == 1) begin
            check("A.op",    64'(bus.op),    64'h0);
            check("A.rs",    64'(bus.rs),    64'd9);
            check("A.rt",    64'(bus.rt),    64'd10);
            check("A.rd",    64'(bus.rd),    64'd8);
            check("A.func",  64'(bus.func),  64'h20);
            check("A.imm16", 64'(bus.imm16), 64'h4020);
            check("A.imm26", 64'(bus.imm26), 64'h012A4020);
         end
         if (i == 3) begin
            check("B.op",    64'(bus.op),    64'h23);
            check("B.rs",    64'(bus.rs),    64'd8);
            check("B.rt",    64'(bus.rt),    64'd9);
            check("B.imm16", 64'(bus.imm16), 64'h0004);
         end
         @(posedge clk);
         #1;
      end
`else
      // empty queue: word consumed the same cycle without being stored
      drive(1'b0, 1'b1, A, 32'h3000, 1'b1);
      @(negedge clk);
      check("byp.count0", 64'(bus.count), 64'd0);
      check_out("byp0", 1'b1, A, 32'h3000);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check("byp.count1", 64'(bus.count), 64'd0);
      check_out("byp1", 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      // empty queue, decode stalled: visible now and also stored
      drive(1'b0, 1'b1, B, 32'h3004, 1'b0);
      @(negedge clk);
      check_out("byp2", 1'b1, B, 32'h3004);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      check("byp.count3", 64'(bus.count), 64'd1);
      check_out("byp3", 1'b1, B, 32'h3004);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check("byp.count4", 64'(bus.count), 64'd0);
      @(posedge clk);
      #1;
`endif

      // asynchronous reset in the middle of a stream
      drive(1'b0, 1'b1, cw(20), 32'h500, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, cw(21), 32'h504, 1'b0);
      @(posedge clk);
      #1;
      check("rst.pre_count", 64'(bus.count), 64'd2);
      #2;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst.count",    64'(bus.count),    64'd0);
      check("rst.in_ready", 64'(bus.in_ready), 64'd1);
      check_out("rst", 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, cw(30), 32'h600, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check("post_rst.count", 64'(bus.count), 64'd1);
      check_out("post_rst", 1'b1, cw(30), 32'h600);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
